// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, memory-stage and RAM-side signals around mem_port_arbiter.
//   slave  : arbiter view (requests, flush and ram_rdata in; grants, returns, stalls, RAM drive out)
//   master : environment view (pipeline requesters plus the RAM model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // Memory-stage port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  // Pipeline control
  logic              flush;
  logic              stall_if;
  logic              stall_mem;
  // RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
    output stall_if, stall_mem, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
    input  stall_if, stall_mem, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (read-only) and the
// memory stage (load/store). One access is granted per cycle; read data returns exactly one
// cycle later and is routed to the requester that owned the access. MEM has priority, but after
// STARVE_MAX consecutive contended MEM wins the fetch side takes the next contended cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave -- requests/grants, read returns, stalls, flush, RAM drive
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] StarveMaxC = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OwnNone,
    OwnIf,
    OwnMem
  } owner_e;

  owner_e     owner_q;
  logic [3:0] starve_q;

  logic if_wins;
  logic mem_gnt;
  logic if_gnt;

  // Fetch only wins a contended cycle once MEM has starved it for STARVE_MAX grants;
  // a flush cancels that win and MEM is served instead.
  always_comb begin
    if_wins = bus.if_req & bus.mem_req & ~bus.flush & (starve_q == StarveMaxC);
    mem_gnt = bus.mem_req & ~if_wins;
    if_gnt  = bus.if_req & ~bus.flush & ~mem_gnt;
  end

  assign bus.mem_gnt   = mem_gnt;
  assign bus.if_gnt    = if_gnt;
  assign bus.stall_if  = bus.if_req & ~if_gnt & ~bus.flush;
  assign bus.stall_mem = bus.mem_req & ~mem_gnt;

  assign bus.ram_en    = mem_gnt | if_gnt;
  assign bus.ram_we    = mem_gnt & bus.mem_we;
  assign bus.ram_addr  = mem_gnt ? bus.mem_addr : bus.if_addr;
  assign bus.ram_wdata = bus.mem_wdata;

  // Returns are steered by who owned last cycle's read; a flush in the return cycle
  // kills a fetch return but never a load return.
  assign bus.if_rvalid  = (owner_q == OwnIf) & ~bus.flush;
  assign bus.if_rdata   = bus.ram_rdata;
  assign bus.mem_rvalid = (owner_q == OwnMem);
  assign bus.mem_rdata  = bus.ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OwnNone;
      starve_q <= 4'd0;
    end else begin
      if (if_gnt) begin
        owner_q <= OwnIf;
      end else if (mem_gnt && !bus.mem_we) begin
        owner_q <= OwnMem;
      end else begin
        owner_q <= OwnNone;
      end

      // Counts MEM grants that kept a live fetch waiting; flush cycles hold the count.
      if (!bus.if_req || if_gnt) begin
        starve_q <= 4'd0;
      end else if (mem_gnt && !bus.flush && (starve_q != StarveMaxC)) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned StarveMax = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(StarveMax)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // RAM model: 256 words addressed by ram_addr[7:0], one-cycle read latency.
  logic [31:0] ram_arr [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_arr[i] = 32'hA5000000 + 32'(i) * 32'h00010101;
    ram_arr[8'h10] = 32'hDEADBEEF;
    bus.ram_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (bus.ram_en) begin
        if (bus.ram_we) ram_arr[bus.ram_addr[7:0]] = bus.ram_wdata;
        else            bus.ram_rdata <= ram_arr[bus.ram_addr[7:0]];
      end
    end
  end

  // Reference model state
  logic [31:0] shadow [256];
  int          pend_owner;   // 0 none, 1 fetch, 2 load
  logic [31:0] pend_data;
  int          streak;       // contended MEM wins since fetch was last served
  logic        last_ig, last_mg, obs_if_gnt;

  int ntotal = 0;
  int npass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, advance model, move to next posedge+1.
  task automatic step(input logic ir, input logic [31:0] ia, input logic mr, input logic mwe,
                      input logic [31:0] ma, input logic [31:0] mwd, input logic fl);
    logic mg, ig;
    bus.if_req = ir; bus.if_addr = ia;
    bus.mem_req = mr; bus.mem_we = mwe; bus.mem_addr = ma; bus.mem_wdata = mwd;
    bus.flush = fl;
    #3;
    mg = mr && !(ir && !fl && streak == StarveMax);
    ig = ir && !fl && !mg;
    obs_if_gnt = bus.if_gnt;
    chk("mem_gnt", bus.mem_gnt, mg);
    chk("if_gnt", bus.if_gnt, ig);
    chk("stall_if", bus.stall_if, ir & ~ig & ~fl);
    chk("stall_mem", bus.stall_mem, mr & ~mg);
    chk("ram_en", bus.ram_en, mg | ig);
    chk("ram_we", bus.ram_we, mg & mwe);
    if (mg || ig) chk("ram_addr", bus.ram_addr, mg ? ma : ia);
    if (mg && mwe) chk("ram_wdata", bus.ram_wdata, mwd);
    chk("if_rvalid", bus.if_rvalid, (pend_owner == 1) && !fl);
    chk("mem_rvalid", bus.mem_rvalid, pend_owner == 2);
    if (pend_owner == 1 && !fl) chk("if_rdata", bus.if_rdata, pend_data);
    if (pend_owner == 2) chk("mem_rdata", bus.mem_rdata, pend_data);
    // Advance the model
    pend_owner = 0;
    if (ig) begin
      pend_owner = 1; pend_data = shadow[ia[7:0]];
    end else if (mg && !mwe) begin
      pend_owner = 2; pend_data = shadow[ma[7:0]];
    end
    if (mg && mwe) shadow[ma[7:0]] = mwd;
    if (!ir || ig) streak = 0;
    else if (mg && !fl && streak < StarveMax) streak++;
    last_ig = ig; last_mg = mg;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_addr = 0; bus.mem_wdata = 0; bus.flush = 0;
  endtask

  task automatic reset_checks();
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_mem_gnt", bus.mem_gnt, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_mem_rvalid", bus.mem_rvalid, 0);
    chk("rst_stall_if", bus.stall_if, 0);
    chk("rst_stall_mem", bus.stall_mem, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    reset_checks();
    pend_owner = 0; streak = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1;
  endtask

  logic        if_act, mem_act, mem_we_r;
  logic [31:0] if_a, mem_a, mem_d;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 32'hA5000000 + 32'(i) * 32'h00010101;
    shadow[8'h10] = 32'hDEADBEEF;
    pend_owner = 0; pend_data = 0; streak = 0;
    last_ig = 0; last_mg = 0; obs_if_gnt = 0;
    rst_n = 0;
    idle_inputs();
    #1;
    @(posedge clk); #1;
    do_reset();

    // Fetch-only read of 0x10, returned next cycle
    step(1, 32'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Contention with counter at 0: load wins, fetch served next cycle
    step(1, 32'h44, 1, 0, 32'h40, 0, 0);
    step(1, 32'h44, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Store then load back
    step(0, 0, 1, 1, 32'h80, 32'h12345678, 0);
    step(0, 0, 1, 0, 32'h80, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Continuous contention: M,M,M,I repeating
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h20, 1, 0, 32'h30, 0, 0);
      chk("starve_pattern", obs_if_gnt, (i % 4) == 3);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    // Flush kills an in-flight fetch; next fetch is served normally
    step(1, 32'h50, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h54, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Flush while starved: MEM keeps winning, fetch takes the first unflushed contention
    for (int i = 0; i < 3; i++) step(1, 32'h24, 1, 0, 32'h34, 0, 0);
    step(1, 32'h24, 1, 0, 32'h34, 0, 1);
    step(1, 32'h24, 1, 0, 32'h34, 0, 1);
    step(1, 32'h24, 1, 0, 32'h34, 0, 0);
    chk("starve_after_flush", obs_if_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    // Reset right after a fetch grant discards the return
    step(1, 32'h60, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 32'h64, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic honouring the hold-until-grant rule
    if_act = 0; mem_act = 0; mem_we_r = 0; if_a = 0; mem_a = 0; mem_d = 0;
    last_ig = 0; last_mg = 0;
    for (int n = 0; n < 400; n++) begin
      if (!if_act || last_ig) begin
        if_act = ($urandom % 3) != 0;
        if_a   = $urandom % 256;
      end else if (($urandom % 20) == 0) begin
        if_act = 0;
      end
      if (!mem_act || last_mg) begin
        mem_act  = ($urandom % 2) != 0;
        mem_we_r = ($urandom % 3) == 0;
        mem_a    = $urandom % 256;
        mem_d    = $urandom;
      end else if (($urandom % 20) == 0) begin
        mem_act = 0;
      end
      step(if_act, if_a, mem_act, mem_we_r, mem_a, mem_d, ($urandom % 7) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
